// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// Module   : wb_arbiter_pkg
// Brief    : Wishbone cycle/burst type encodings and index-width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_arbiter_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INC     = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  // Bits needed to hold an index in 0..value-1 (at least 1).
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// Module   : wb_rr_arbiter
// Brief    : Round-robin grant register; owner keeps the grant while it requests.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  output logic [N-1:0]          grant,
  output logic [clog2(N)-1:0]   sel,
  output logic                  active
);

  localparam int IW = clog2(N);

  logic [N-1:0]  r_grant;
  logic [IW-1:0] r_last;
  logic [N-1:0]  w_grant_nxt;
  logic [IW-1:0] w_last_nxt;
  logic          w_found;
  int            w_idx;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    w_grant_nxt = '0;
    w_last_nxt  = r_last;
    w_found     = 1'b0;
    w_idx       = 0;
    if (|(r_grant & req)) begin
      w_grant_nxt = r_grant;
    end else begin
      for (int i = 1; i <= N; i++) begin
        w_idx = (int'(r_last) + i) % N;
        if (!w_found && req[w_idx]) begin
          w_found            = 1'b1;
          w_grant_nxt[w_idx] = 1'b1;
          w_last_nxt         = IW'(w_idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_last  <= IW'(N - 1);
    end else begin
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign grant  = r_grant;
  assign sel    = r_last;
  assign active = |r_grant;

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Brief    : Wishbone B3 N-to-1 arbiter: owner mux plus response routing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int NUM_MASTERS = 5
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_MASTERS*aw-1:0]     wbm_adr_i,
  input  logic [NUM_MASTERS*dw-1:0]     wbm_dat_i,
  input  logic [NUM_MASTERS*dw/8-1:0]   wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]        wbm_we_i,
  input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]      wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      wbm_bte_i,
  output logic [dw-1:0]                 wbm_dat_o,
  output logic [NUM_MASTERS-1:0]        wbm_ack_o,
  output logic [NUM_MASTERS-1:0]        wbm_err_o,
  output logic [NUM_MASTERS-1:0]        wbm_rty_o,
  output logic [aw-1:0]                 wbs_adr_o,
  output logic [dw-1:0]                 wbs_dat_o,
  output logic [dw/8-1:0]               wbs_sel_o,
  output logic                          wbs_we_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  input  logic [dw-1:0]                 wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i
);

  localparam int IW = clog2(NUM_MASTERS);
  localparam int SW = dw / 8;

  logic [NUM_MASTERS-1:0] w_grant;
  logic [IW-1:0]          w_sel;
  logic                   w_active;
  int                     w_k;

  wb_rr_arbiter #(
    .N      (NUM_MASTERS)
  ) u_rr_arbiter (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_i),
    .req    (wbm_cyc_i),
    .grant  (w_grant),
    .sel    (w_sel),
    .active (w_active)
  );

  // Idle bus presents all-zero request fields to the slave.
  always_comb begin
    w_k       = int'(w_sel);
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    if (w_active) begin
      wbs_adr_o = wbm_adr_i[w_k*aw +: aw];
      wbs_dat_o = wbm_dat_i[w_k*dw +: dw];
      wbs_sel_o = wbm_sel_i[w_k*SW +: SW];
      wbs_we_o  = wbm_we_i[w_k];
      wbs_cyc_o = wbm_cyc_i[w_k];
      wbs_stb_o = wbm_stb_i[w_k];
      wbs_cti_o = wbm_cti_i[w_k*3 +: 3];
      wbs_bte_o = wbm_bte_i[w_k*2 +: 2];
    end
  end

  assign wbm_ack_o = w_grant & {NUM_MASTERS{wbs_ack_i}};
  assign wbm_err_o = w_grant & {NUM_MASTERS{wbs_err_i}};
  assign wbm_rty_o = w_grant & {NUM_MASTERS{wbs_rty_i}};
  assign wbm_dat_o = wbs_dat_i;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Scoreboard bench for wb_arbiter with directed master scenarios.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NM = 5;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] adr [NM];
  logic [DW-1:0] dat [NM];
  logic [3:0]    sel [NM];
  logic [2:0]    cti [NM];
  logic [1:0]    bte [NM];
  logic [NM-1:0] cyc, stb, we;

  logic [NM*AW-1:0]   wbm_adr_i;
  logic [NM*DW-1:0]   wbm_dat_i;
  logic [NM*DW/8-1:0] wbm_sel_i;
  logic [NM*3-1:0]    wbm_cti_i;
  logic [NM*2-1:0]    wbm_bte_i;
  logic [DW-1:0]      wbm_dat_o;
  logic [NM-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]      wbs_adr_o;
  logic [DW-1:0]      wbs_dat_o;
  logic [3:0]         wbs_sel_o;
  logic               wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]         wbs_cti_o;
  logic [1:0]         wbs_bte_o;
  logic [DW-1:0]      wbs_dat_i;
  logic               wbs_ack_i, wbs_err_i, wbs_rty_i;

  genvar g;
  for (g = 0; g < NM; g++) begin : g_flat
    assign wbm_adr_i[g*AW +: AW] = adr[g];
    assign wbm_dat_i[g*DW +: DW] = dat[g];
    assign wbm_sel_i[g*4 +: 4]   = sel[g];
    assign wbm_cti_i[g*3 +: 3]   = cti[g];
    assign wbm_bte_i[g*2 +: 2]   = bte[g];
  end

  wb_arbiter #(.dw(DW), .aw(AW), .NUM_MASTERS(NM)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(we), .wbm_cyc_i(cyc), .wbm_stb_i(stb),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i)
  );

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
    logic          we;
    logic [2:0]    cti;
    logic [NM-1:0] ack;
    logic [NM-1:0] err;
    logic [DW-1:0] rdat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beat for master k: slave sees k's fields, only k gets the response.
  task automatic push_exp(input int k, input bit is_err, input logic [DW-1:0] rdat);
    exp_t e;
    e.adr  = adr[k];
    e.dat  = dat[k];
    e.sel  = sel[k];
    e.we   = we[k];
    e.cti  = cti[k];
    e.ack  = is_err ? '0 : NM'(1 << k);
    e.err  = is_err ? NM'(1 << k) : '0;
    e.rdat = rdat;
    sb_q.push_back(e);
  endtask

  // Called in master k's granted cycle: one beat, then release and check the idle gap.
  task automatic xfer(input int k, input bit is_err, input logic [DW-1:0] rdat);
    wbs_dat_i = rdat;
    wbs_ack_i = !is_err;
    wbs_err_i = is_err;
    push_exp(k, is_err, rdat);
    tick();
    cyc[k] = 1'b0;
    stb[k] = 1'b0;
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    @(negedge clk);
    check("idle_gap_cyc", wbs_cyc_o, 0);
    check("idle_gap_ack", wbm_ack_o, 0);
    tick();
  endtask

  always @(negedge clk) begin
    if (rst_n && wbs_cyc_o && wbs_stb_o && (wbs_ack_i || wbs_err_i)) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got beat adr %0h expected no beat", wbs_adr_o);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_adr",  wbs_adr_o, mon_e.adr);
        check("sb_dat",  wbs_dat_o, mon_e.dat);
        check("sb_sel",  wbs_sel_o, mon_e.sel);
        check("sb_we",   wbs_we_o,  mon_e.we);
        check("sb_cti",  wbs_cti_o, mon_e.cti);
        check("sb_ack",  wbm_ack_o, mon_e.ack);
        check("sb_err",  wbm_err_o, mon_e.err);
        check("sb_rty",  wbm_rty_o, 0);
        check("sb_rdat", wbm_dat_o, mon_e.rdat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < NM; k++) begin
      adr[k] = AW'(32'h1000 * (k + 1));
      dat[k] = 32'hA000_0000 + DW'(k);
      sel[k] = 4'hF;
      cti[k] = CTI_CLASSIC;
      bte[k] = BTE_LINEAR;
    end
    we = '0;
    wbs_dat_i = '0;
    wbs_err_i = 1'b0;
    wbs_rty_i = 1'b0;

    // Reset held with every master requesting and the slave acking.
    rst_n = 1'b0;
    cyc = '1;
    stb = '1;
    wbs_ack_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", wbs_cyc_o, 0);
    check("rst_stb", wbs_stb_o, 0);
    check("rst_ack", wbm_ack_o, 0);
    check("rst_adr", wbs_adr_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wbs_ack_i = 1'b0;
    @(negedge clk);
    check("post_rst_idle", wbs_cyc_o, 0);
    tick();
    @(negedge clk);
    check("first_grant_cyc", wbs_cyc_o, 1);
    check("first_grant_adr", wbs_adr_o, adr[0]);
    @(posedge clk);
    #1;
    cyc = '0;
    stb = '0;
    @(negedge clk);
    check("release_idle", wbs_cyc_o, 0);
    tick();

    // Single write from master 3.
    adr[3] = 32'h100;
    dat[3] = 32'hDEAD_BEEF;
    sel[3] = 4'hF;
    we[3]  = 1'b1;
    cyc[3] = 1'b1;
    stb[3] = 1'b1;
    tick();
    xfer(3, 1'b0, 32'h1234_5678);

    // Fresh reset so the rotation starts at master 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    adr[3] = 32'h4000;
    dat[3] = 32'hA000_0003;
    we = '0;
    cyc = '1;
    stb = '1;
    tick();
    for (int s = 0; s < 6; s++) begin
      xfer(s % NM, 1'b0, 32'hC0DE_0000 + DW'(s));
      if (s == 0) begin
        cyc[0] = 1'b1;
        stb[0] = 1'b1;
      end
    end

    // Master 1 bursts while master 2 waits.
    adr[1] = 32'h200;
    cti[1] = CTI_INC;
    cyc[1] = 1'b1;
    stb[1] = 1'b1;
    cyc[2] = 1'b1;
    stb[2] = 1'b1;
    tick();
    for (int b = 0; b < 8; b++) begin
      adr[1] = 32'h200 + AW'(4 * b);
      cti[1] = (b == 7) ? CTI_EOB : CTI_INC;
      wbs_dat_i = 32'hB000_0000 + DW'(b);
      wbs_ack_i = 1'b1;
      push_exp(1, 1'b0, wbs_dat_i);
      tick();
    end
    cyc[1] = 1'b0;
    stb[1] = 1'b0;
    wbs_ack_i = 1'b0;
    @(negedge clk);
    check("burst_end_idle", wbs_cyc_o, 0);
    check("burst_end_ack", wbm_ack_o, 0);
    tick();
    xfer(2, 1'b1, 32'h0000_00EE);

    // Reset in the middle of master 4's cycle.
    cyc[4] = 1'b1;
    stb[4] = 1'b1;
    tick();
    @(negedge clk);
    check("m4_grant_cyc", wbs_cyc_o, 1);
    check("m4_grant_adr", wbs_adr_o, adr[4]);
    #1;
    rst_n = 1'b0;
    cyc[0] = 1'b1;
    stb[0] = 1'b1;
    #1;
    check("midrst_cyc", wbs_cyc_o, 0);
    check("midrst_stb", wbs_stb_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    xfer(0, 1'b0, 32'h5A5A_5A5A);
    cyc = '0;
    stb = '0;
    tick();

    @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
